// File: rtl/rr_arb_16.sv
// rr_arb_16: 16-way round-robin arbiter with registered one-hot grant.
// Optional hold timeout (MAX_HOLD cycles) compiled in with RR_ARB_TIMEOUT_EN.
module rr_arb_16 #(
  parameter int MAX_HOLD = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_id,
  output logic        gnt_valid,
  output logic        timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nx;
  logic [3:0] last_id, pick, idx, id_nx;
  logic found, rel, expire;
`ifdef RR_ARB_TIMEOUT_EN
  logic [15:0] hold_cnt, hold_nx;
  assign expire = hold_cnt == 16'(MAX_HOLD);
`else
  assign expire = 1'b0;
  assign timeout = 1'b0;
`endif
  // first set request searching upward from last_id+1, wrapping
  always_comb begin
    pick = 4'd0;
    found = 1'b0;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      idx = last_id + 4'(i + 1);
      if (!found && req[idx]) begin
        pick = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    rel = done || !req[gnt_id];
    state_nx = state == IDLE ? (found ? GRANT : IDLE) : (rel || expire ? IDLE : GRANT);
    id_nx = state_nx == GRANT ? (state == IDLE ? pick : gnt_id) : 4'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt <= 16'd0;
      gnt_id <= 4'd0;
      gnt_valid <= 1'b0;
      last_id <= 4'hf;
    end else begin
      state <= state_nx;
      gnt <= state_nx == GRANT ? 16'd1 << id_nx : 16'd0;
      gnt_id <= id_nx;
      gnt_valid <= state_nx == GRANT;
      if (state == IDLE && found) last_id <= pick;
    end
  end
`ifdef RR_ARB_TIMEOUT_EN
  // a normal release in the same cycle as expiry wins, so no timeout pulse
  assign hold_nx = state_nx == GRANT ? (state == IDLE ? 16'd1 : hold_cnt + 16'd1) : 16'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= 16'd0;
      timeout <= 1'b0;
    end else begin
      hold_cnt <= hold_nx;
      timeout <= state == GRANT && !rel && expire;
    end
  end
`endif
endmodule

// File: doc/rr_arb_16.md
RR_ARB_16 -- requirements
Module: rr_arb_16

Interface
REQ-001 SHALL have parameter: MAX_HOLD, 64, maximum grant length in cycles when timeout is compiled in (legal range 2..65535).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: req  input  16  request vector, bit i = requester i.
REQ-005 SHALL have port: done  input  1  release pulse from current grant holder.
REQ-006 SHALL have port: gnt  output  16  one-hot grant vector, all-zero when idle.
REQ-007 SHALL have port: gnt_id  output  4  binary index of current grant, 0 when idle.
REQ-008 SHALL have port: gnt_valid  output  1  high while any grant is held.
REQ-009 SHALL have port: timeout  output  1  one-cycle pulse on forced revoke.

Function
REQ-010 SHALL implement two states: IDLE, GRANT; all outputs registered.
REQ-011 SHALL, in IDLE with req nonzero at edge t, enter GRANT with gnt, gnt_id, gnt_valid valid after edge t+1 (1-cycle latency).
REQ-012 SHALL select the first set req bit searching upward from last_id+1, wrapping 15->0 (round-robin).
REQ-013 SHALL update last_id to the granted index on entry to GRANT.
REQ-014 SHALL keep gnt one-hot and gnt == (1 << gnt_id) whenever gnt_valid=1; gnt=0, gnt_id=0 otherwise.
REQ-015 SHALL hold grant unchanged while in GRANT, ignoring changes to other req bits.
REQ-016 SHALL release (return to IDLE, outputs cleared after the edge) when done=1 or req[gnt_id]=0 is sampled in GRANT.
REQ-017 SHALL spend at least one cycle in IDLE between grants; earliest re-grant is two edges after the release sample.
REQ-018 SHALL ignore done while in IDLE.
REQ-019 SHALL, with done=1 and a timeout coinciding, treat it as normal release (timeout=0).
REQ-020 SHALL remain in IDLE with all outputs zero when req=0.

Reset
REQ-021 SHALL, when rst=1 at an edge, set state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, last_id=15, hold counter=0.
REQ-022 SHALL take rst priority over all other inputs, including mid-grant; grant drops at that edge.
REQ-023 SHALL grant requester 0 first after reset if req[0]=1 (follows from last_id=15).

Configuration
REQ-024 SHALL gate the hold timeout with macro RR_ARB_TIMEOUT_EN.
REQ-025 SHALL, with RR_ARB_TIMEOUT_EN defined, count cycles in GRANT and force release so gnt_valid is high for at most MAX_HOLD cycles, pulsing timeout=1 for one cycle concurrent with the first IDLE cycle.
REQ-026 SHALL, without RR_ARB_TIMEOUT_EN, hold grants indefinitely, omit the counter logic, and tie timeout to 0; MAX_HOLD unused.
REQ-027 SHALL advance the round-robin pointer identically after forced and normal release.

Verification
REQ-028 SHALL cover: reset, req=16'h0001 -> after next edge gnt=16'h0001, gnt_id=0, gnt_valid=1; done pulse -> gnt=0 next edge.
REQ-029 SHALL cover: req=16'hFFFF held, done pulsed each grant -> gnt_id sequence 0,1,2,...,15,0, one IDLE cycle between each.
REQ-030 SHALL cover: last_id=5, req=16'h0021 -> gnt_id=0 (wrap past 6..15), then next grant gnt_id=5.
REQ-031 SHALL cover: granted id 3, req drops to 16'h0000 with done=0 -> gnt=0, gnt_valid=0 after next edge.
REQ-032 SHALL cover (RR_ARB_TIMEOUT_EN, MAX_HOLD=4): req=16'h0003 held, done=0 -> gnt_id=0 valid exactly 4 cycles, timeout pulse 1 cycle, then gnt_id=1.
REQ-033 SHALL cover: rst=1 during GRANT of id 7 -> all outputs 0 after edge; on release of rst with req=16'h0080 -> gnt_id=7 after one edge.
